// File: rtl/bus_arbiter.sv
// Two-port round-robin bus arbiter: instruction fetch (port 0) and data (port 1)
// share one system bus; an in-order tag FIFO routes read returns back to their issuer.
module bus_arbiter #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset_n,

    output logic        p0_ready,
    input  logic [29:0] p0_addr,
    input  logic [3:0]  p0_byte_enable,
    input  logic        p0_read_req,
    output logic [31:0] p0_read_data,
    output logic        p0_read_data_valid,

    output logic        p1_ready,
    input  logic [29:0] p1_addr,
    input  logic [31:0] p1_write_data,
    input  logic [3:0]  p1_byte_enable,
    input  logic        p1_read_req,
    input  logic        p1_write_req,
    output logic [31:0] p1_read_data,
    output logic        p1_read_data_valid,

    input  logic        bus_ready,
    output logic [29:0] bus_addr,
    output logic [31:0] bus_write_data,
    output logic [3:0]  bus_byte_enable,
    output logic        bus_read_req,
    output logic        bus_write_req,
    input  logic [31:0] bus_read_data,
    input  logic        bus_read_data_valid,

    output logic        protocol_error
);

    localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    logic          r_tag [MAX_OUTSTANDING];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_last_grant;
    logic          r_protocol_error;

    logic w_full;
    logic w_empty;
    logic w_p0_elig;
    logic w_p1_elig;
    logic w_g0;
    logic w_g1;
    logic w_accept;
    logic w_push;
    logic w_push_tag;
    logic w_pop;
    logic w_head;
    logic w_stray;

    assign w_full  = (r_count == MAX_CNT);
    assign w_empty = (r_count == '0);

    // Reads stall on a full tag FIFO; writes never need a tag slot.
    assign w_p0_elig = reset_n & p0_read_req & ~w_full;
    assign w_p1_elig = reset_n & (p1_write_req | (p1_read_req & ~w_full));

    assign w_g0 = w_p0_elig & (~w_p1_elig | r_last_grant);
    assign w_g1 = w_p1_elig & (~w_p0_elig | ~r_last_grant);

    assign w_accept   = bus_ready & (w_g0 | w_g1);
    assign w_push     = bus_ready & ((w_g0 & p0_read_req) | (w_g1 & p1_read_req));
    assign w_push_tag = w_g1;

    assign w_head  = r_tag[r_rd_ptr];
    assign w_pop   = bus_read_data_valid & ~w_empty;
    assign w_stray = bus_read_data_valid & w_empty;

    assign p0_ready = bus_ready & w_g0;
    assign p1_ready = bus_ready & w_g1;

    assign bus_addr        = w_g1 ? p1_addr        : p0_addr;
    assign bus_byte_enable = w_g1 ? p1_byte_enable : p0_byte_enable;
    assign bus_write_data  = w_g1 ? p1_write_data  : 32'h0;
    assign bus_read_req    = (w_g0 & p0_read_req) | (w_g1 & p1_read_req);
    assign bus_write_req   = w_g1 & p1_write_req;

    assign p0_read_data       = bus_read_data;
    assign p1_read_data       = bus_read_data;
    assign p0_read_data_valid = w_pop & ~w_head;
    assign p1_read_data_valid = w_pop & w_head;

    assign protocol_error = r_protocol_error;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                r_tag[i] <= 1'b0;
            end
        end else if (w_push) begin
            r_tag[r_wr_ptr] <= w_push_tag;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Starting at port 1 hands the first contention to port 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_last_grant <= w_g1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_protocol_error <= 1'b0;
        end else if (w_stray) begin
            r_protocol_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed-vector bench for bus_arbiter: arbitration order, tag routing,
// full-FIFO blocking, stray returns and reset behaviour.
module tb_bus_arbiter;

    logic        clk;
    logic        reset_n;
    logic        p0_ready;
    logic [29:0] p0_addr;
    logic [3:0]  p0_byte_enable;
    logic        p0_read_req;
    logic [31:0] p0_read_data;
    logic        p0_read_data_valid;
    logic        p1_ready;
    logic [29:0] p1_addr;
    logic [31:0] p1_write_data;
    logic [3:0]  p1_byte_enable;
    logic        p1_read_req;
    logic        p1_write_req;
    logic [31:0] p1_read_data;
    logic        p1_read_data_valid;
    logic        bus_ready;
    logic [29:0] bus_addr;
    logic [31:0] bus_write_data;
    logic [3:0]  bus_byte_enable;
    logic        bus_read_req;
    logic        bus_write_req;
    logic [31:0] bus_read_data;
    logic        bus_read_data_valid;
    logic        protocol_error;

    int n_checks;
    int n_fail;

    bus_arbiter #(.MAX_OUTSTANDING(4)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .p0_ready            (p0_ready),
        .p0_addr             (p0_addr),
        .p0_byte_enable      (p0_byte_enable),
        .p0_read_req         (p0_read_req),
        .p0_read_data        (p0_read_data),
        .p0_read_data_valid  (p0_read_data_valid),
        .p1_ready            (p1_ready),
        .p1_addr             (p1_addr),
        .p1_write_data       (p1_write_data),
        .p1_byte_enable      (p1_byte_enable),
        .p1_read_req         (p1_read_req),
        .p1_write_req        (p1_write_req),
        .p1_read_data        (p1_read_data),
        .p1_read_data_valid  (p1_read_data_valid),
        .bus_ready           (bus_ready),
        .bus_addr            (bus_addr),
        .bus_write_data      (bus_write_data),
        .bus_byte_enable     (bus_byte_enable),
        .bus_read_req        (bus_read_req),
        .bus_write_req       (bus_write_req),
        .bus_read_data       (bus_read_data),
        .bus_read_data_valid (bus_read_data_valid),
        .protocol_error      (protocol_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after an edge; checks run 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        p0_read_req         = 1'b0;
        p1_read_req         = 1'b0;
        p1_write_req        = 1'b0;
        bus_read_data_valid = 1'b0;
    endtask

    task automatic ret(input logic [31:0] d);
        bus_read_data       = d;
        bus_read_data_valid = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n             = 1'b0;
        p0_addr             = 30'h100;
        p0_byte_enable      = 4'hF;
        p1_addr             = 30'h200;
        p1_write_data       = 32'h0;
        p1_byte_enable      = 4'h3;
        bus_ready           = 1'b1;
        bus_read_data       = 32'h0;
        idle();
        p0_read_req = 1'b1;
        #12;
        check("rst_bus_read_req", bus_read_req, 0);
        check("rst_bus_write_req", bus_write_req, 0);
        check("rst_perr", protocol_error, 0);
        idle();
        tick();
        reset_n = 1'b1;
        tick();

        // Contention: grants alternate starting at port 0
        p0_read_req = 1'b1;
        p1_read_req = 1'b1;
        settle();
        check("rr1_p0_ready", p0_ready, 1);
        check("rr1_p1_ready", p1_ready, 0);
        check("rr1_addr", bus_addr, 30'h100);
        check("rr1_rreq", bus_read_req, 1);
        tick(); settle();
        check("rr2_p1_ready", p1_ready, 1);
        check("rr2_p0_ready", p0_ready, 0);
        check("rr2_addr", bus_addr, 30'h200);
        check("rr2_be", bus_byte_enable, 4'h3);
        tick(); settle();
        check("rr3_p0_ready", p0_ready, 1);
        tick(); settle();
        check("rr4_p1_ready", p1_ready, 1);
        tick(); settle();
        check("rr5_full_p0", p0_ready, 0);
        check("rr5_full_p1", p1_ready, 0);
        check("rr5_full_rreq", bus_read_req, 0);
        ret(32'hA0);
        settle();
        check("rr6_p0_valid", p0_read_data_valid, 1);
        check("rr6_p1_valid", p1_read_data_valid, 0);
        check("rr6_p0_ready", p0_ready, 0);
        tick();
        bus_read_data_valid = 1'b0;
        settle();
        check("rr7_p0_ready", p0_ready, 1);
        check("rr7_p1_ready", p1_ready, 0);
        tick();
        idle();
        // Tags now: p1, p0, p1, p0
        ret(32'hB1); settle();
        check("dr1_p1_valid", p1_read_data_valid, 1);
        check("dr1_p0_valid", p0_read_data_valid, 0);
        tick(); settle();
        check("dr2_p0_valid", p0_read_data_valid, 1);
        tick(); settle();
        check("dr3_p1_valid", p1_read_data_valid, 1);
        tick(); settle();
        check("dr4_p0_valid", p0_read_data_valid, 1);
        tick();
        idle();
        settle();
        check("dr_done_perr", protocol_error, 0);

        // Two reads, returns routed in issue order
        p0_read_req = 1'b1;
        settle();
        check("io_p0_ready", p0_ready, 1);
        tick();
        idle();
        p1_read_req = 1'b1;
        settle();
        check("io_p1_ready", p1_ready, 1);
        tick();
        idle();
        ret(32'h11111111); settle();
        check("io_ret1_p0v", p0_read_data_valid, 1);
        check("io_ret1_p1v", p1_read_data_valid, 0);
        check("io_ret1_data", p0_read_data, 32'h11111111);
        tick();
        ret(32'h22222222); settle();
        check("io_ret2_p1v", p1_read_data_valid, 1);
        check("io_ret2_p0v", p0_read_data_valid, 0);
        check("io_ret2_data", p1_read_data, 32'h22222222);
        check("io_ret2_p0data", p0_read_data, 32'h22222222);
        tick();
        idle();

        // Fill with four port 0 reads, then a write gets through
        p0_read_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("fill_p0_ready", p0_ready, 1);
            tick();
        end
        p1_write_req   = 1'b1;
        p1_addr        = 30'h10;
        p1_write_data  = 32'hDEADBEEF;
        p1_byte_enable = 4'hF;
        settle();
        check("wr_p0_ready", p0_ready, 0);
        check("wr_p1_ready", p1_ready, 1);
        check("wr_wreq", bus_write_req, 1);
        check("wr_rreq", bus_read_req, 0);
        check("wr_addr", bus_addr, 30'h10);
        check("wr_data", bus_write_data, 32'hDEADBEEF);
        check("wr_be", bus_byte_enable, 4'hF);
        tick();
        idle();
        // Full: return and new p1 read in the same cycle
        p1_read_req = 1'b1;
        p1_addr     = 30'h44;
        ret(32'h33);
        settle();
        check("fr_p1_ready0", p1_ready, 0);
        check("fr_p0_valid", p0_read_data_valid, 1);
        tick();
        bus_read_data_valid = 1'b0;
        settle();
        check("fr_p1_ready1", p1_ready, 1);
        check("fr_addr", bus_addr, 30'h44);
        tick(); settle();
        check("fr_full_again", p1_ready, 0);
        idle();
        // Tags: p0, p0, p0, p1
        ret(32'h1); settle();
        check("fd1_p0v", p0_read_data_valid, 1);
        tick(); settle();
        check("fd2_p0v", p0_read_data_valid, 1);
        tick(); settle();
        check("fd3_p0v", p0_read_data_valid, 1);
        tick(); settle();
        check("fd4_p1v", p1_read_data_valid, 1);
        check("fd4_p0v", p0_read_data_valid, 0);
        tick();
        idle();

        // Stray return with empty FIFO
        ret(32'h55); settle();
        check("st_p0v", p0_read_data_valid, 0);
        check("st_p1v", p1_read_data_valid, 0);
        check("st_perr_now", protocol_error, 0);
        tick();
        idle();
        settle();
        check("st_perr_next", protocol_error, 1);
        tick(); tick(); settle();
        check("st_perr_sticky", protocol_error, 1);
        reset_n = 1'b0;
        settle();
        check("st_perr_rst", protocol_error, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // Reset with two reads in flight discards their tags
        p0_read_req = 1'b1;
        p1_read_req = 1'b1;
        tick(); tick();
        idle();
        reset_n = 1'b0;
        settle();
        check("mr_rreq_rst", bus_read_req, 0);
        tick();
        reset_n   = 1'b1;
        bus_ready = 1'b0;
        p0_read_req = 1'b1;
        p1_read_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("nr_p0_ready", p0_ready, 0);
            check("nr_p1_ready", p1_ready, 0);
            tick();
        end
        idle();
        ret(32'h77); settle();
        check("mr_stray_p0v", p0_read_data_valid, 0);
        check("mr_stray_p1v", p1_read_data_valid, 0);
        tick();
        idle();
        settle();
        check("mr_perr", protocol_error, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
